// File: rtl/mem_access_stage.sv
// Memory access stage: issues one req/ack data-memory transaction per load/store,
// formats load data and hands a registered result bundle to writeback.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [5:0]  instr_id_in,
    input  logic        rd_valid_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [31:0] rd_value_in,
    input  logic [31:0] rs2_value_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        valid_out,
    output logic        rd_valid_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_value_out,
    output logic [31:0] mem_data_out,
    output logic [5:0]  instr_id_out,
    output logic        misalign_out,
    output logic        bus_err_out
);
    // state | meaning
    // IDLE  | accepting a new bundle from EX/MEM
    // BUSY  | memory transaction outstanding, upstream stalled

    localparam logic [5:0] ID_LB  = 6'd10;
    localparam logic [5:0] ID_LH  = 6'd11;
    localparam logic [5:0] ID_LW  = 6'd12;
    localparam logic [5:0] ID_LBU = 6'd13;
    localparam logic [5:0] ID_LHU = 6'd14;
    localparam logic [5:0] ID_SB  = 6'd15;
    localparam logic [5:0] ID_SH  = 6'd16;
    localparam logic [5:0] ID_SW  = 6'd17;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [5:0]        lat_id;
    logic              lat_rd_valid;
    logic [4:0]        lat_rd_addr;
    logic [31:0]       lat_rd_value;
    logic [1:0]        lat_off;

    logic        is_load, is_store, misaligned, issue, timeout;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata, rshift, load_fmt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        st_wstrb   = 4'b0000;
        st_wdata   = 32'h0;
        case (instr_id_in)
            ID_LB, ID_LBU: is_load = 1'b1;
            ID_LH, ID_LHU: begin
                is_load    = 1'b1;
                misaligned = rd_value_in[0];
            end
            ID_LW: begin
                is_load    = 1'b1;
                misaligned = |rd_value_in[1:0];
            end
            ID_SB: begin
                is_store = 1'b1;
                st_wstrb = 4'b0001 << rd_value_in[1:0];
                st_wdata = {4{rs2_value_in[7:0]}};
            end
            ID_SH: begin
                is_store   = 1'b1;
                misaligned = rd_value_in[0];
                st_wstrb   = 4'b0011 << rd_value_in[1:0];
                st_wdata   = {2{rs2_value_in[15:0]}};
            end
            ID_SW: begin
                is_store   = 1'b1;
                misaligned = |rd_value_in[1:0];
                st_wstrb   = 4'b1111;
                st_wdata   = rs2_value_in;
            end
            default: ;
        endcase
    end

    assign issue   = (state == S_IDLE) && valid_in && (is_load || is_store) && !misaligned;
    // An ack in the timeout cycle wins, so timeout is qualified by !dmem_ack.
    assign timeout = (state == S_BUSY) && !dmem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign rshift  = dmem_rdata >> {lat_off, 3'b000};
    assign ld_byte = rshift[7:0];
    assign ld_half = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_fmt = 32'h0;
        case (lat_id)
            ID_LB:   load_fmt = {{24{ld_byte[7]}}, ld_byte};
            ID_LBU:  load_fmt = {24'h0, ld_byte};
            ID_LH:   load_fmt = {{16{ld_half[15]}}, ld_half};
            ID_LHU:  load_fmt = {16'h0, ld_half};
            ID_LW:   load_fmt = dmem_rdata;
            default: load_fmt = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (issue) state_nxt = S_BUSY;
            S_BUSY:  if (dmem_ack || timeout) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stall_out = (state == S_BUSY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                                cnt <= '0;
        else if (issue)                            cnt <= '0;
        else if ((state == S_BUSY) && !dmem_ack)   cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= 32'h0;
            dmem_wstrb   <= 4'b0000;
            dmem_wdata   <= 32'h0;
            valid_out    <= 1'b0;
            rd_valid_out <= 1'b0;
            rd_addr_out  <= 5'h0;
            rd_value_out <= 32'h0;
            mem_data_out <= 32'h0;
            instr_id_out <= 6'h0;
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;
            lat_id       <= 6'h0;
            lat_rd_valid <= 1'b0;
            lat_rd_addr  <= 5'h0;
            lat_rd_value <= 32'h0;
            lat_off      <= 2'b00;
        end else begin
            valid_out    <= 1'b0;
            misalign_out <= 1'b0;
            bus_err_out  <= 1'b0;
            if (state == S_IDLE) begin
                if (issue) begin
                    lat_id       <= instr_id_in;
                    lat_rd_valid <= rd_valid_in;
                    lat_rd_addr  <= rd_addr_in;
                    lat_rd_value <= rd_value_in;
                    lat_off      <= rd_value_in[1:0];
                    dmem_req     <= 1'b1;
                    dmem_we      <= is_store;
                    dmem_addr    <= {rd_value_in[31:2], 2'b00};
                    dmem_wstrb   <= st_wstrb;
                    dmem_wdata   <= st_wdata;
                end else if (valid_in) begin
                    valid_out    <= 1'b1;
                    misalign_out <= misaligned;
                    rd_valid_out <= rd_valid_in && !misaligned;
                    rd_addr_out  <= rd_addr_in;
                    rd_value_out <= rd_value_in;
                    mem_data_out <= 32'h0;
                    instr_id_out <= instr_id_in;
                end
            end else if (dmem_ack || timeout) begin
                dmem_req     <= 1'b0;
                valid_out    <= 1'b1;
                bus_err_out  <= !dmem_ack;
                rd_valid_out <= dmem_ack && lat_rd_valid;
                rd_addr_out  <= lat_rd_addr;
                rd_value_out <= lat_rd_value;
                mem_data_out <= dmem_ack ? load_fmt : 32'h0;
                instr_id_out <= lat_id;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: expected writeback bundles are queued at
// stimulus time and compared whenever valid_out fires.
module tb_mem_access_stage;
    localparam logic [5:0] ID_ADD = 6'd1;
    localparam logic [5:0] ID_LB  = 6'd10;
    localparam logic [5:0] ID_LH  = 6'd11;
    localparam logic [5:0] ID_LW  = 6'd12;
    localparam logic [5:0] ID_LBU = 6'd13;
    localparam logic [5:0] ID_SB  = 6'd15;
    localparam logic [5:0] ID_SH  = 6'd16;
    localparam logic [5:0] ID_SW  = 6'd17;

    logic        clk, rst_n, valid_in, rd_valid_in, dmem_ack;
    logic [5:0]  instr_id_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] rd_value_in, rs2_value_in, dmem_rdata;
    logic        stall_out, dmem_req, dmem_we, valid_out, rd_valid_out, misalign_out, bus_err_out;
    logic [31:0] dmem_addr, dmem_wdata, rd_value_out, mem_data_out;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  rd_addr_out;
    logic [5:0]  instr_id_out;

    typedef struct packed {
        logic        rd_valid;
        logic [4:0]  rd_addr;
        logic [31:0] rd_value;
        logic [31:0] mem;
        logic [5:0]  id;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr_id_in(instr_id_in),
        .rd_valid_in(rd_valid_in), .rd_addr_in(rd_addr_in), .rd_value_in(rd_value_in),
        .rs2_value_in(rs2_value_in), .stall_out(stall_out), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .valid_out(valid_out), .rd_valid_out(rd_valid_out), .rd_addr_out(rd_addr_out),
        .rd_value_out(rd_value_out), .mem_data_out(mem_data_out),
        .instr_id_out(instr_id_out), .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic rdv, input logic [4:0] rda, input logic [31:0] rdval,
                        input logic [31:0] mem, input logic [5:0] id, input logic mis,
                        input logic berr);
        exp_t e;
        e.rd_valid = rdv;
        e.rd_addr  = rda;
        e.rd_value = rdval;
        e.mem      = mem;
        e.id       = id;
        e.mis      = mis;
        e.berr     = berr;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [5:0] id, input logic rdv, input logic [4:0] rda,
                         input logic [31:0] rdval, input logic [31:0] rs2);
        valid_in     = 1'b1;
        instr_id_in  = id;
        rd_valid_in  = rdv;
        rd_addr_in   = rda;
        rd_value_in  = rdval;
        rs2_value_in = rs2;
    endtask

    // Issues one aligned load/store, acks after wait_n extra BUSY cycles.
    task automatic issue_mem(input string tag, input logic [5:0] id, input logic rdv,
                             input logic [4:0] rda, input logic [31:0] addr,
                             input logic [31:0] rs2, input int wait_n,
                             input logic [31:0] rdata, input logic [31:0] exp_mem,
                             input logic exp_we, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata);
        logic [31:0] waddr;
        int stall_n;
        waddr = {addr[31:2], 2'b00};
        drive(id, rdv, rda, addr, rs2);
        push(rdv, rda, addr, exp_mem, id, 1'b0, 1'b0);
        tick();
        valid_in = 1'b0;
        chk({tag, "_req"}, 32'(dmem_req), 32'd1);
        chk({tag, "_addr"}, dmem_addr, waddr);
        chk({tag, "_we"}, 32'(dmem_we), 32'(exp_we));
        chk({tag, "_wstrb"}, 32'(dmem_wstrb), 32'(exp_strb));
        chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
        stall_n = 0;
        for (int i = 0; i <= wait_n; i++) begin
            if (stall_out) stall_n++;
            if (i == wait_n) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            tick();
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        chk({tag, "_stall_cycles"}, 32'(stall_n), 32'(wait_n + 1));
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out observed=valid_out expected=no_result id=%0d", instr_id_out);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_rd_valid", 32'(rd_valid_out), 32'(e.rd_valid));
                chk("out_rd_addr", 32'(rd_addr_out), 32'(e.rd_addr));
                chk("out_rd_value", rd_value_out, e.rd_value);
                chk("out_mem_data", mem_data_out, e.mem);
                chk("out_instr_id", 32'(instr_id_out), 32'(e.id));
                chk("out_misalign", 32'(misalign_out), 32'(e.mis));
                chk("out_bus_err", 32'(bus_err_out), 32'(e.berr));
            end
        end
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        drive(ID_ADD, 1'b1, 5'd5, 32'h1234, 32'h0);
        repeat (3) tick();
        chk("rst_ctrl", {16'h0, stall_out, dmem_req, dmem_we, dmem_wstrb, valid_out,
                         rd_valid_out, misalign_out, bus_err_out, rd_addr_out},
            32'h0);
        chk("rst_id", 32'(instr_id_out), 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_rd_value", rd_value_out, 32'h0);
        chk("rst_mem_data", mem_data_out, 32'h0);

        rst_n = 1'b1;
        push(1'b1, 5'd5, 32'h1234, 32'h0, ID_ADD, 1'b0, 1'b0);
        tick();
        chk("add_valid", 32'(valid_out), 32'd1);
        valid_in = 1'b0;
        tick();
        chk("bubble_valid", 32'(valid_out), 32'd0);

        issue_mem("lb",  ID_LB,  1'b1, 5'd3, 32'h103, 32'h0, 3, 32'h80FF_0000,
                  32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0);
        issue_mem("lbu", ID_LBU, 1'b1, 5'd4, 32'h103, 32'h0, 3, 32'h80FF_0000,
                  32'h0000_0080, 1'b0, 4'b0000, 32'h0);
        issue_mem("sh",  ID_SH,  1'b0, 5'd0, 32'h202, 32'hABCD_1234, 0, 32'hFFFF_FFFF,
                  32'h0, 1'b1, 4'b1100, 32'h1234_1234);
        issue_mem("lh",  ID_LH,  1'b1, 5'd6, 32'h102, 32'h0, 1, 32'h8001_7FFF,
                  32'hFFFF_8001, 1'b0, 4'b0000, 32'h0);
        issue_mem("sb",  ID_SB,  1'b0, 5'd0, 32'h101, 32'h0000_00AB, 2, 32'h0,
                  32'h0, 1'b1, 4'b0010, 32'hABAB_ABAB);
        issue_mem("sw",  ID_SW,  1'b0, 5'd0, 32'h300, 32'h1122_3344, 0, 32'h0,
                  32'h0, 1'b1, 4'b1111, 32'h1122_3344);

        drive(ID_LW, 1'b1, 5'd8, 32'h005, 32'h0);
        push(1'b0, 5'd8, 32'h005, 32'h0, ID_LW, 1'b1, 1'b0);
        tick();
        valid_in = 1'b0;
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_stall", 32'(stall_out), 32'd0);

        drive(ID_LW, 1'b1, 5'd9, 32'h040, 32'h0);
        push(1'b0, 5'd9, 32'h040, 32'h0, ID_LW, 1'b0, 1'b1);
        tick();
        valid_in = 1'b0;
        n = 0;
        while (dmem_req && n < 40) begin
            n++;
            tick();
        end
        chk("to_req_cycles", 32'(n), 32'd16);
        chk("to_valid", 32'(valid_out), 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_5555;
        tick();
        dmem_ack = 1'b0;
        chk("late_ack_valid", 32'(valid_out), 32'd0);
        chk("late_ack_stall", 32'(stall_out), 32'd0);

        drive(ID_LW, 1'b1, 5'd7, 32'h080, 32'h0);
        push(1'b1, 5'd7, 32'h080, 32'hDEAD_BEEF, ID_LW, 1'b0, 1'b0);
        tick();
        drive(ID_ADD, 1'b1, 5'd9, 32'h55, 32'h0);
        push(1'b1, 5'd9, 32'h55, 32'h0, ID_ADD, 1'b0, 1'b0);
        chk("b2b_stall", 32'(stall_out), 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        chk("b2b_lw_id", 32'(instr_id_out), 32'(ID_LW));
        tick();
        valid_in = 1'b0;
        chk("b2b_add_id", 32'(instr_id_out), 32'(ID_ADD));
        chk("b2b_add_valid", 32'(valid_out), 32'd1);

        drive(ID_LW, 1'b1, 5'd2, 32'h0C0, 32'h0);
        tick();
        valid_in = 1'b0;
        chk("rstbusy_req_on", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rstbusy_req_off", 32'(dmem_req), 32'd0);
        chk("rstbusy_stall", 32'(stall_out), 32'd0);
        rst_n = 1'b1;

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly upstream of the writeback stage. Takes the EX/MEM instruction bundle and issues one data-memory transaction per load/store over a req/ack handshake.
- Aligns and sign/zero-extends load data. Presents a registered bundle (valid, rd info, ALU value, formatted load data, instr_id) to writeback.
- Stalls upstream while a transaction is outstanding. Aborts on misalignment or ack timeout.

Parameters:
- TIMEOUT_CYCLES, 16, number of BUSY cycles without dmem_ack before abort; legal range 2..255.
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- valid_in  in  1  EX/MEM bundle valid (0 = bubble).
- instr_id_in  in  6  instruction ID from instr_defines.vh.
- rd_valid_in  in  1  instruction writes rd.
- rd_addr_in  in  5  destination register.
- rd_value_in  in  32  ALU result; the effective address for loads/stores.
- rs2_value_in  in  32  store data.
- stall_out  out  1  upstream must hold its bundle while high.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address ({addr[31:2],2'b00}).
- dmem_wstrb  out  4  byte strobes.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- valid_out  out  1  bundle to writeback valid.
- rd_valid_out  out  1  forwarded rd_valid; forced 0 on an aborted access.
- rd_addr_out  out  5  forwarded.
- rd_value_out  out  32  forwarded ALU value.
- mem_data_out  out  32  formatted load data; 0 for non-loads.
- instr_id_out  out  6  forwarded.
- misalign_out  out  1  one-cycle pulse, coincident with valid_out.
- bus_err_out  out  1  one-cycle pulse on timeout abort, coincident with valid_out.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, counter=0. All outputs 0: stall_out, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, valid_out, rd_valid_out, rd_addr_out, rd_value_out, mem_data_out, instr_id_out, misalign_out, bus_err_out.
  - Reset mid-transaction drops dmem_req the next cycle.
  - An ack arriving in IDLE is ignored.
- Memory ops: LB, LH, LW, LBU, LHU (loads); SB, SH, SW (stores).
- Misaligned when:
  - LH/LHU/SH with addr[0]=1, or
  - LW/SW with addr[1:0]!=0.
- FSM has two states, IDLE and BUSY. stall_out = (state==BUSY), combinational.
- IDLE, valid_in=0: next cycle valid_out=0, pulses 0.
- IDLE, valid non-memory op: next cycle valid_out=1 with all fields forwarded, mem_data_out=0. Latency 1.
- IDLE, valid misaligned memory op:
  - No request is issued.
  - Next cycle valid_out=1, misalign_out=1, rd_valid_out=0, other fields forwarded.
- IDLE, valid aligned memory op:
  - Latch instr_id, rd info, rd_value and offset=addr[1:0]; drive dmem_* next cycle with dmem_req=1.
  - Go to BUSY with counter=0; valid_out=0 while BUSY.
- BUSY:
  - dmem_req and all dmem_* fields stay stable until ack or abort.
  - Counter increments each cycle without ack.
- BUSY, dmem_ack=1:
  - Next cycle dmem_req=0, state=IDLE.
  - valid_out=1 with latched fields; mem_data_out = formatted dmem_rdata (0 for stores).
  - Memory-op latency = 2 + ack wait cycles. The next upstream bundle is accepted the cycle after the ack.
- BUSY, counter reaches TIMEOUT_CYCLES-1 without ack:
  - Abort: next cycle dmem_req=0, state=IDLE.
  - valid_out=1, bus_err_out=1, rd_valid_out=0.
  - An ack in the same cycle as the timeout wins; no error.
- Load formatting, with byte b = rdata[8*off+7:8*off] and half h = rdata[16*off[1]+15:16*off[1]]:
  - LB: sign-extend b. LBU: zero-extend b.
  - LH: sign-extend h. LHU: zero-extend h.
  - LW: the full word.
- Store formatting:
  - SB: wstrb=4'b0001<<off, wdata={4{rs2[7:0]}}.
  - SH: wstrb=4'b0011<<off, wdata={2{rs2[15:0]}}.
  - SW: wstrb=4'b1111, wdata=rs2.
- Loads: dmem_we=0, wstrb=4'b0000.
- valid_out, misalign_out and bus_err_out are single-cycle unless a new result is produced the next cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with valid_in=1 ADD -> all outputs 0. Release -> ADD (rd_addr=5, rd_value=0x1234) appears with valid_out=1 one cycle later, mem_data_out=0.
- LB at addr 0x103, ack after 3 cycles, rdata=0x80FF_0000 -> dmem_addr=0x100, wstrb=0, stall_out high 4 cycles, mem_data_out=0xFFFF_FF80. LBU on the same access -> 0x0000_0080.
- SH at addr 0x202, rs2=0xABCD_1234, immediate ack -> dmem_we=1, wstrb=4'b1100, wdata=0x1234_1234, valid_out=1 and mem_data_out=0 on the cycle after the ack.
- LW at addr 0x005 -> no dmem_req, next cycle valid_out=1, misalign_out=1, rd_valid_out=0.
- LW with no ack, TIMEOUT_CYCLES=16 -> dmem_req held exactly 16 cycles, then bus_err_out=1 with valid_out=1 and rd_valid_out=0. A late ack afterwards is ignored.
- Back-to-back LW then ADD, ack on the 1st BUSY cycle -> ADD held by stall_out and emitted the cycle after the LW result. rst_n=0 while BUSY -> dmem_req=0 next cycle.
